// File: rtl/gal_pkg.sv
// GAL-style OLMC array: mode codes and config frame layout.
// Frame bit k (0 = first sent) ends up at shadow[CFG_BITS-1-k].
package gal_pkg;

  localparam logic [1:0] MODE_COMB     = 2'b00;
  localparam logic [1:0] MODE_COMB_INV = 2'b01;
  localparam logic [1:0] MODE_REG      = 2'b10;
  localparam logic [1:0] MODE_REG_INV  = 2'b11;

  function automatic int cfg_bits(
    input int n,
    input int m,
    input int p
  );
    return 2*p*(n+m) + m*p + 2*m;
  endfunction

  // l = 2*s selects signal s true, l = 2*s+1 its complement
  function automatic int and_pos(
    input int n,
    input int m,
    input int p,
    input int t,
    input int l
  );
    return cfg_bits(n, m, p) - 1 - (t*2*(n+m) + l);
  endfunction

  function automatic int or_pos(
    input int n,
    input int m,
    input int p,
    input int o,
    input int t
  );
    return cfg_bits(n, m, p) - 1 - (2*p*(n+m) + o*p + t);
  endfunction

  // position of the mode MSB; the LSB sits one below
  function automatic int mode_pos(
    input int n,
    input int m,
    input int p,
    input int o
  );
    return cfg_bits(n, m, p) - 1 - (2*p*(n+m) + m*p + 2*o);
  endfunction

endpackage

// File: rtl/pal_plane.sv
// Programmable AND/OR plane: product terms over true/complement
// literals, then per-output OR of selected terms.
module pal_plane
  import gal_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4,
  parameter int P = 14
) (
  input  logic [N+M-1:0]                lits,
  input  logic [P-1:0][2*(N+M)-1:0]     and_cfg,
  input  logic [M-1:0][P-1:0]           or_cfg,
  output logic [M-1:0]                  sums
);

  localparam int L = N + M;

  logic [2*L-1:0] lit_pair;
  logic [P-1:0]   terms;

  always_comb begin
    lit_pair = '0;
    for (int s = 0; s < L; s++) begin
      lit_pair[2*s]   = lits[s];
      lit_pair[2*s+1] = ~lits[s];
    end
  end

  // an empty term is 0; x & ~x also falls out as 0
  always_comb begin
    terms = '0;
    for (int t = 0; t < P; t++) begin
      terms[t] = (|and_cfg[t])
               & (&(~and_cfg[t] | lit_pair));
    end
  end

  always_comb begin
    sums = '0;
    for (int o = 0; o < M; o++) begin
      sums[o] = |(or_cfg[o] & terms);
    end
  end

endmodule

// File: rtl/gal_olmc_array.sv
// Serially configured GAL-style array: config shifter, frame
// counter, active config and output macrocells.
module gal_olmc_array
  import gal_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4,
  parameter int P = 14
) (
  input  logic         CLK,
  input  logic         RES,
  input  logic         EN,
  input  logic         CFG_EN,
  input  logic         CFG,
  output logic         CFG_OUT,
  output logic         CFG_VALID,
  input  logic [N-1:0] INPUT_VARS,
  output logic [M-1:0] OUTPUT_VALS
);

  localparam int CFG_BITS = cfg_bits(N, M, P);
  localparam int L        = N + M;
  localparam int CW       = $clog2(CFG_BITS);
  localparam logic [CW-1:0] LAST = CW'(CFG_BITS - 1);

  logic [CFG_BITS-1:0]      shadow;
  logic [CFG_BITS-1:0]      active;
  logic [CW-1:0]            cnt;
  logic                     pend;
  logic                     valid;
  logic [M-1:0]             q;
  logic [M-1:0]             sums;
  logic [M-1:0]             y;
  logic [P-1:0][2*L-1:0]    and_cfg;
  logic [M-1:0][P-1:0]      or_cfg;
  logic [M-1:0][1:0]        mode;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      shadow <= '0;
      cnt    <= '0;
      pend   <= 1'b0;
    end else begin
      pend <= CFG_EN && (cnt == LAST);
      if (CFG_EN) begin
        shadow <= {shadow[CFG_BITS-2:0], CFG};
        cnt    <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
    end
  end

  // frame is committed the cycle after its last bit
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      active <= '0;
      valid  <= 1'b0;
    end else if (pend) begin
      active <= shadow;
      valid  <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      q <= '0;
    end else if (EN) begin
      q <= sums;
    end
  end

  for (genvar t = 0; t < P; t++) begin : g_and
    for (genvar l = 0; l < 2*L; l++) begin : g_lit
      assign and_cfg[t][l] =
        active[and_pos(N, M, P, t, l)];
    end
  end

  for (genvar o = 0; o < M; o++) begin : g_out
    for (genvar t = 0; t < P; t++) begin : g_or
      assign or_cfg[o][t] =
        active[or_pos(N, M, P, o, t)];
    end
    assign mode[o] = {
      active[mode_pos(N, M, P, o)],
      active[mode_pos(N, M, P, o) - 1]
    };
  end

  pal_plane #(
    .N (N),
    .M (M),
    .P (P)
  ) u_plane (
    .lits    ({q, INPUT_VARS}),
    .and_cfg (and_cfg),
    .or_cfg  (or_cfg),
    .sums    (sums)
  );

  always_comb begin
    y = '0;
    for (int o = 0; o < M; o++) begin
      unique case (mode[o])
        MODE_COMB:     y[o] = sums[o];
        MODE_COMB_INV: y[o] = ~sums[o];
        MODE_REG:      y[o] = q[o];
        MODE_REG_INV:  y[o] = ~q[o];
      endcase
    end
  end

  assign OUTPUT_VALS = valid ? y : '0;
  assign CFG_VALID   = valid;
  assign CFG_OUT     = shadow[CFG_BITS-1];

endmodule

// File: tb/tb_gal_olmc_array.sv
// Randomized bench for gal_olmc_array against a structural
// config model (literal/term/mode arrays, bit-history readback).
module tb_gal_olmc_array;

  localparam int N  = 8;
  localparam int M  = 4;
  localparam int P  = 14;
  localparam int L  = N + M;
  localparam int CB = 2*P*L + M*P + 2*M;

  typedef struct packed {
    logic [P-1:0][L-1:0] en_t;
    logic [P-1:0][L-1:0] en_c;
    logic [M-1:0][P-1:0] orp;
    logic [M-1:0][1:0]   mode;
  } cfg_t;

  logic         CLK = 1'b0;
  logic         RES = 1'b0;
  logic         EN = 1'b0;
  logic         CFG_EN = 1'b0;
  logic         CFG = 1'b0;
  logic         CFG_OUT;
  logic         CFG_VALID;
  logic [N-1:0] INPUT_VARS = '0;
  logic [M-1:0] OUTPUT_VALS;

  int n_vec = 0;
  int n_err = 0;

  cfg_t         act_m;
  cfg_t         pend_cfg;
  bit           pend_m;
  bit           valid_m;
  logic [M-1:0] q_m;
  bit           hist[$];
  bit           fq[$];
  bit           qa[$];

  gal_olmc_array #(.N(N), .M(M), .P(P)) dut (
    .CLK         (CLK),
    .RES         (RES),
    .EN          (EN),
    .CFG_EN      (CFG_EN),
    .CFG         (CFG),
    .CFG_OUT     (CFG_OUT),
    .CFG_VALID   (CFG_VALID),
    .INPUT_VARS  (INPUT_VARS),
    .OUTPUT_VALS (OUTPUT_VALS)
  );

  always #5 CLK = ~CLK;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [M-1:0] model_sums(
    input logic [N-1:0] vars
  );
    logic [L-1:0] lit;
    logic [M-1:0] s;
    bit any, ok;
    lit = {q_m, vars};
    s = '0;
    for (int t = 0; t < P; t++) begin
      any = 0;
      ok  = 1;
      for (int i = 0; i < L; i++) begin
        if (act_m.en_t[t][i]) begin
          any = 1;
          if (!lit[i]) ok = 0;
        end
        if (act_m.en_c[t][i]) begin
          any = 1;
          if (lit[i]) ok = 0;
        end
      end
      for (int o = 0; o < M; o++)
        if (act_m.orp[o][t] && any && ok) s[o] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [M-1:0] model_out(
    input logic [N-1:0] vars
  );
    logic [M-1:0] s, r;
    bit v;
    s = model_sums(vars);
    r = '0;
    if (valid_m) begin
      for (int o = 0; o < M; o++) begin
        v = act_m.mode[o][1] ? q_m[o] : s[o];
        r[o] = v ^ act_m.mode[o][0];
      end
    end
    return r;
  endfunction

  function automatic bit exp_cfg_out();
    if (hist.size() >= CB) return hist[hist.size() - CB];
    return 1'b0;
  endfunction

  // frame order: AND plane term by term, OR plane, modes
  function automatic void ser(input cfg_t c);
    fq.delete();
    for (int t = 0; t < P; t++)
      for (int i = 0; i < L; i++) begin
        fq.push_back(c.en_t[t][i]);
        fq.push_back(c.en_c[t][i]);
      end
    for (int o = 0; o < M; o++)
      for (int t = 0; t < P; t++)
        fq.push_back(c.orp[o][t]);
    for (int o = 0; o < M; o++) begin
      fq.push_back(c.mode[o][1]);
      fq.push_back(c.mode[o][0]);
    end
  endfunction

  function automatic cfg_t deser(input int base);
    cfg_t c;
    int k;
    c = '0;
    k = base;
    for (int t = 0; t < P; t++)
      for (int i = 0; i < L; i++) begin
        c.en_t[t][i] = hist[k];
        c.en_c[t][i] = hist[k+1];
        k += 2;
      end
    for (int o = 0; o < M; o++)
      for (int t = 0; t < P; t++) begin
        c.orp[o][t] = hist[k];
        k++;
      end
    for (int o = 0; o < M; o++) begin
      c.mode[o] = {hist[k], hist[k+1]};
      k += 2;
    end
    return c;
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c = '0;
    for (int t = 0; t < P; t++)
      for (int i = 0; i < L; i++) begin
        c.en_t[t][i] = ($urandom % 9) == 0;
        c.en_c[t][i] = ($urandom % 9) == 0;
      end
    for (int o = 0; o < M; o++) begin
      for (int t = 0; t < P; t++)
        c.orp[o][t] = ($urandom % 3) == 0;
      c.mode[o] = 2'($urandom);
    end
    return c;
  endfunction

  // called at negedge, returns at the next negedge
  task automatic tick(
    input bit           en,
    input bit           ce,
    input bit           cb,
    input logic [N-1:0] vars
  );
    logic [M-1:0] s;
    EN = en;
    CFG_EN = ce;
    CFG = cb;
    INPUT_VARS = vars;
    #1;
    check("outv", OUTPUT_VALS, model_out(vars));
    check("valid", CFG_VALID, valid_m);
    check("cfgout", CFG_OUT, exp_cfg_out());
    s = model_sums(vars);
    @(posedge CLK);
    if (en) q_m = s;
    if (pend_m) begin
      act_m = pend_cfg;
      valid_m = 1;
      pend_m = 0;
    end
    if (ce) begin
      hist.push_back(cb);
      if (hist.size() % CB == 0) begin
        pend_cfg = deser(hist.size() - CB);
        pend_m = 1;
      end
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    EN = 0;
    CFG_EN = 0;
    RES = 1;
    #2;
    hist.delete();
    act_m = '0;
    pend_m = 0;
    valid_m = 0;
    q_m = '0;
    check("rst_out", OUTPUT_VALS, 0);
    check("rst_valid", CFG_VALID, 0);
    check("rst_cfgout", CFG_OUT, 0);
    #1;
    RES = 0;
    @(negedge CLK);
  endtask

  task automatic load(input cfg_t c);
    ser(c);
    for (int i = 0; i < CB; i++)
      tick(0, 1, fq[i], N'($urandom));
  endtask

  cfg_t f1, fa, fb, fz;

  initial begin
    act_m = '0;
    pend_cfg = '0;
    pend_m = 0;
    valid_m = 0;
    q_m = '0;

    // out0 = in0 & ~in1 (comb), out1 = ~q1 (registered)
    f1 = '0;
    f1.en_t[0][0] = 1'b1;
    f1.en_c[0][1] = 1'b1;
    f1.orp[0][0] = 1'b1;
    f1.mode[0] = 2'b00;
    f1.en_c[1][N+1] = 1'b1;
    f1.orp[1][1] = 1'b1;
    f1.mode[1] = 2'b10;

    do_reset();

    fa = rand_cfg();
    ser(fa);
    for (int i = 0; i < 150; i++)
      tick(0, 1, fq[i], N'($urandom));
    do_reset();

    load(f1);
    check("valid_early", CFG_VALID, 0);
    tick(0, 0, 0, 8'h00);
    check("valid_rise", CFG_VALID, 1);

    INPUT_VARS = 8'h01;
    #1;
    check("comb_01", OUTPUT_VALS[0], 1);
    INPUT_VARS = 8'h03;
    #1;
    check("comb_03", OUTPUT_VALS[0], 0);

    for (int i = 0; i < 4; i++) begin
      check("toggle", OUTPUT_VALS[1], i % 2);
      tick(1, 0, 0, N'($urandom));
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, N'($urandom));
      check("hold0", OUTPUT_VALS[1], 0);
    end
    tick(1, 0, 0, N'($urandom));
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, N'($urandom));
      check("hold1", OUTPUT_VALS[1], 1);
    end

    do_reset();
    ser(f1);
    qa = fq;
    for (int i = 0; i < 200; i++)
      tick(0, 1, qa[i], N'($urandom));
    for (int i = 0; i < 10; i++)
      tick(0, 0, 1'($urandom), N'($urandom));
    for (int i = 200; i < CB; i++)
      tick(0, 1, qa[i], N'($urandom));
    check("pause_early", CFG_VALID, 0);
    tick(0, 0, 0, 8'h00);
    check("pause_valid", CFG_VALID, 1);
    INPUT_VARS = 8'h01;
    #1;
    check("pause_01", OUTPUT_VALS[0], 1);
    INPUT_VARS = 8'h03;
    #1;
    check("pause_03", OUTPUT_VALS[0], 0);
    check("pause_t0", OUTPUT_VALS[1], 0);
    tick(1, 0, 0, 8'h00);
    check("pause_t1", OUTPUT_VALS[1], 1);

    do_reset();
    fa = rand_cfg();
    fb = rand_cfg();
    load(fa);
    for (int i = 0; i < 20; i++)
      tick(1'($urandom), 0, 0, N'($urandom));
    ser(fa);
    qa = fq;
    ser(fb);
    for (int i = 0; i < CB; i++) begin
      check("readback", CFG_OUT, qa[i]);
      tick(1'($urandom), 1, fq[i], N'($urandom));
    end
    for (int i = 0; i < 30; i++)
      tick(1'($urandom), 0, 0, N'($urandom));

    do_reset();
    fz = '0;
    load(fz);
    tick(0, 0, 0, 8'h00);
    check("zero_valid", CFG_VALID, 1);
    for (int i = 0; i < 6; i++) begin
      tick(1'($urandom), 0, 0, N'($urandom));
      check("zero_out", OUTPUT_VALS, 0);
    end
    fz.mode = {M{2'b01}};
    load(fz);
    tick(0, 0, 0, 8'h5a);
    for (int i = 0; i < 6; i++) begin
      tick(1'($urandom), 0, 0, N'($urandom));
      check("inv_empty", OUTPUT_VALS, {M{1'b1}});
    end

    for (int r = 0; r < 4; r++) begin
      load(rand_cfg());
      for (int i = 0; i < 120; i++)
        tick(1'($urandom), 0, 0, N'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
